// File: rtl/alu_pkg.sv
// Shared types, opcode encodings and the bitwise result function for the
// dual-mode logic ALU and its event tables.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef logic [1:0] op_t;

  typedef enum logic {MODE_A = 1'b0, MODE_B = 1'b1} mode_e;

  typedef struct packed {
    logic             valid;
    op_t              op;
    logic [ALU_W-1:0] val;
  } evt_entry_t;

  localparam op_t OP_A_AND  = 2'b00;
  localparam op_t OP_A_NAND = 2'b01;
  localparam op_t OP_A_OR   = 2'b10;
  localparam op_t OP_A_XOR  = 2'b11;
  localparam op_t OP_B_XNOR = 2'b00;
  localparam op_t OP_B_AND  = 2'b01;
  localparam op_t OP_B_NOR  = 2'b10;
  localparam op_t OP_B_OR   = 2'b11;

  function automatic logic [ALU_W-1:0] alu_calc(mode_e mode, op_t op,
                                                logic [ALU_W-1:0] a,
                                                logic [ALU_W-1:0] b);
    logic [ALU_W-1:0] r;
    r = '0;
    if (mode == MODE_A) begin
      case (op)
        OP_A_AND:  r = a & b;
        OP_A_NAND: r = ~(a & b);
        OP_A_OR:   r = a | b;
        default:   r = a ^ b;
      endcase
    end else begin
      case (op)
        OP_B_XNOR: r = ~(a ^ b);
        OP_B_AND:  r = a & b;
        OP_B_NOR:  r = ~(a | b);
        default:   r = a | b;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_event_core_if.sv
// ALU operand/result bus plus event-table configuration port.
// Handshake: none -- alu_enable qualifies a compute cycle, cfg_we a table
// write; both are sampled on every rising clock edge with no back-pressure.
interface alu_event_core_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_EVT = 4
);
  localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

  logic              alu_enable;
  logic              alu_enable_a;
  logic              alu_enable_b;
  logic [1:0]        alu_op_a;
  logic [1:0]        alu_op_b;
  logic [DATA_W-1:0] alu_in_a;
  logic [DATA_W-1:0] alu_in_b;
  logic              alu_irq_clr;
  logic              cfg_we;
  logic              cfg_mode;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_valid;
  logic [1:0]        cfg_op;
  logic [DATA_W-1:0] cfg_val;
  logic [DATA_W-1:0] alu_out;
  logic              alu_irq;
  logic              alu_err;

  modport master (
    output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
           alu_in_a, alu_in_b, alu_irq_clr,
           cfg_we, cfg_mode, cfg_idx, cfg_valid, cfg_op, cfg_val,
    input  alu_out, alu_irq, alu_err
  );

  modport slave (
    input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
           alu_in_a, alu_in_b, alu_irq_clr,
           cfg_we, cfg_mode, cfg_idx, cfg_valid, cfg_op, cfg_val,
    output alu_out, alu_irq, alu_err
  );

endinterface

// File: rtl/alu_evt_table.sv
// One mode's event table: NUM_EVT programmable {valid, op, val} entries and
// a combinational "any valid entry equals {op, result}" match.
module alu_evt_table
  import alu_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  evt_entry_t       wr_entry,
  input  op_t              op,
  input  logic [ALU_W-1:0] result,
  output logic             match
);

  evt_entry_t tbl [NUM_EVT];

  // Out-of-range indices only exist for non power-of-two tables; drop them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EVT; i++) tbl[i] <= '0;
    end else if (we && (int'(idx) < NUM_EVT)) begin
      tbl[idx] <= wr_entry;
    end
  end

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (tbl[i].valid && (tbl[i].op == op) && (tbl[i].val == result))
        match = 1'b1;
    end
  end

endmodule

// File: rtl/alu_event_core.sv
// Dual-mode 8-bit logic ALU with registered result, illegal-select flag and
// a sticky interrupt raised when {op, result} hits the active mode's table.
module alu_event_core
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_W,
  parameter int NUM_EVT = 4
) (
  input logic clk,
  input logic rst_n,
  alu_event_core_if.slave bus
);

  localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

  logic              legal;
  logic              illegal;
  mode_e             mode;
  op_t               active_op;
  logic [DATA_W-1:0] result;
  logic              match_a;
  logic              match_b;
  logic              hit;
  evt_entry_t        wr_entry;
  logic [DATA_W-1:0] out_q;
  logic              irq_q;
  logic              err_q;

  assign legal     = bus.alu_enable && (bus.alu_enable_a ^ bus.alu_enable_b);
  assign illegal   = bus.alu_enable && !(bus.alu_enable_a ^ bus.alu_enable_b);
  assign mode      = bus.alu_enable_b ? MODE_B : MODE_A;
  assign active_op = (mode == MODE_B) ? bus.alu_op_b : bus.alu_op_a;
  assign result    = alu_calc(mode, active_op, bus.alu_in_a, bus.alu_in_b);
  assign wr_entry  = '{valid: bus.cfg_valid, op: bus.cfg_op, val: bus.cfg_val};

  alu_evt_table #(.NUM_EVT(NUM_EVT), .IDX_W(IDX_W)) u_tbl_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bus.cfg_we && (bus.cfg_mode == MODE_A)),
    .idx      (bus.cfg_idx),
    .wr_entry (wr_entry),
    .op       (active_op),
    .result   (result),
    .match    (match_a)
  );

  alu_evt_table #(.NUM_EVT(NUM_EVT), .IDX_W(IDX_W)) u_tbl_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bus.cfg_we && (bus.cfg_mode == MODE_B)),
    .idx      (bus.cfg_idx),
    .wr_entry (wr_entry),
    .op       (active_op),
    .result   (result),
    .match    (match_b)
  );

  // Only the active mode's table counts, and only on a legal cycle.
  assign hit = legal && ((mode == MODE_B) ? match_b : match_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      irq_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (legal) out_q <= result;
      err_q <= illegal;
      // A match outranks a same-cycle clear.
      if (hit)                  irq_q <= 1'b1;
      else if (bus.alu_irq_clr) irq_q <= 1'b0;
    end
  end

  assign bus.alu_out = out_q;
  assign bus.alu_irq = irq_q;
  assign bus.alu_err = err_q;

endmodule
